// File: rtl/t03_sprite_loader_if.sv
// Memory read bus between the sprite loader (master) and the cache/memory system (slave).
// One outstanding request at a time: mem_req is held until the cycle mem_ack returns data.
interface t03_sprite_loader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/t03_sprite_loader.sv
// Fetches one sprite from memory into a back buffer word by word, then copies it to the
// front buffer on frame_sync so the display stage only ever sees a complete sprite.
module t03_sprite_loader #(
  parameter int PIX_W  = 15,
  parameter int PIX_H  = 20,
  parameter int BPP    = 8,
  parameter int WORD_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic [31:0]                  base_addr,
  input  logic                         frame_sync,
  t03_sprite_loader_if.master          mem,
  output logic [PIX_W*PIX_H*BPP-1:0]   sprite,
  output logic                         sprite_valid,
  output logic                         busy,
  output logic                         swap_done
);

  localparam int SPRITE_W  = PIX_W * PIX_H * BPP;
  localparam int NUM_WORDS = SPRITE_W / WORD_W;
  localparam int CNT_W     = 7;

  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(NUM_WORDS - 1);
  localparam logic [31:0]      WORD_BYTES = 32'(WORD_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_SWAP
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [SPRITE_W-1:0]  back;
  logic [CNT_W-1:0]     word_cnt;

  logic accept;
  logic capture;
  logic last_word;
  logic swap;

  // State register.
  // NOTE: every clocked block uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (load_start) next_state = FETCH;
      FETCH:     if (mem.mem_req && mem.mem_ack && word_cnt == LAST_WORD) next_state = WAIT_SWAP;
      WAIT_SWAP: if (frame_sync) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Per-cycle control strobes decoded from the current state.
  always_comb begin
    accept    = 1'b0;
    capture   = 1'b0;
    last_word = 1'b0;
    swap      = 1'b0;
    case (state)
      IDLE: begin
        accept = load_start;
      end
      FETCH: begin
        // An ack with no request outstanding is not a transfer.
        capture   = mem.mem_req && mem.mem_ack;
        last_word = mem.mem_req && mem.mem_ack && (word_cnt == LAST_WORD);
      end
      WAIT_SWAP: begin
        swap = frame_sync;
      end
      default: begin
        accept = 1'b0;
      end
    endcase
  end

  // Request/address sequencing. The address only moves after an ack, so it is held
  // stable through any number of wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      word_cnt     <= '0;
      busy         <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      if (accept) begin
        mem.mem_req  <= 1'b1;
        mem.mem_addr <= base_addr;
        word_cnt     <= '0;
      end else if (capture) begin
        word_cnt <= word_cnt + 1'b1;
        if (last_word) begin
          mem.mem_req <= 1'b0;
        end else begin
          mem.mem_addr <= mem.mem_addr + WORD_BYTES;
        end
      end
    end
  end

  // Back buffer: word k lands at the top-down slot k, so the first-fetched byte is pixel 0.
  // NOTE: the buffers are reset on purpose so a reset-then-swap never exposes stale pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      back <= '0;
    end else if (capture) begin
      back[SPRITE_W-1-WORD_W*int'(word_cnt) -: WORD_W] <= mem.mem_rdata;
    end
  end

  // Front buffer and swap status: the front only ever changes as a whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      sprite       <= '0;
      sprite_valid <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= swap;
      if (swap) begin
        sprite       <= back;
        sprite_valid <= 1'b1;
      end
    end
  end

endmodule
